// File: rtl/fp_mant_normalizer_if.sv
// Handshake bundle for the mantissa normalizer: upstream beat (valid/ready,
// sign, rounding mode, biased exponent, raw magnitude) and the normalized
// downstream beat with its zero/overflow/underflow flags.
interface fp_mant_normalizer_if #(
    parameter int IN_W   = 48,
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [1:0]        in_rmode;
    logic [EXP_W+1:0]  in_exp;
    logic [IN_W-1:0]   in_mag;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [1:0]        out_rmode;
    logic [EXP_W-1:0]  out_exp;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;

    // Producer of input beats and consumer of output beats.
    modport master (
        output in_valid, in_sign, in_rmode, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_sign, out_rmode, out_exp, out_data,
               out_zero, out_ovf, out_unf
    );

    // The normalizer itself.
    modport slave (
        input  in_valid, in_sign, in_rmode, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_sign, out_rmode, out_exp, out_data,
               out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_mant_normalizer.sv
// Two-stage mantissa normalizer. S1 captures the beat and locates the leading
// one; S2 shifts it out as the hidden bit, collapses the discarded tail into a
// sticky bit, rebiases the exponent and resolves zero/underflow/overflow.
module fp_mant_normalizer #(
    parameter int IN_W   = 48,
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input logic                clk,
    input logic                rst_n,
    fp_mant_normalizer_if.slave bus
);
    localparam int PW   = $clog2(IN_W);
    localparam int FW   = IN_W - 1;                    // fraction width after hidden bit drop
    localparam int PADW = (FW > DATA_W) ? FW : DATA_W; // fraction padded to at least DATA_W
    localparam int XW   = EXP_W + 3;                   // signed exponent arithmetic width
    localparam logic signed [XW-1:0] EXP_INF = XW'((1 << EXP_W) - 1);

    // S1 state
    logic              s1_valid_q;
    logic              s1_sign_q;
    logic [1:0]        s1_rmode_q;
    logic [EXP_W+1:0]  s1_exp_q;
    logic [IN_W-1:0]   s1_mag_q;
    logic [PW-1:0]     s1_p_q;
    logic              s1_zero_q;

    // S2 (output) state
    logic              out_valid_q;
    logic              out_sign_q;
    logic [1:0]        out_rmode_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_zero_q;
    logic              out_ovf_q;
    logic              out_unf_q;

    // S2 next-state values computed from S1
    logic [EXP_W-1:0]  out_exp_d;
    logic [DATA_W-1:0] out_data_d;
    logic              out_zero_d;
    logic              out_ovf_d;
    logic              out_unf_d;

    logic              s2_load;
    logic              in_ready;
    logic [PW-1:0]     lead_p;

    logic [PW-1:0]          shamt;
    logic [IN_W-1:0]        shifted;
    logic [PADW-1:0]        frac_pad;
    logic [PADW-1:0]        tail;
    logic [DATA_W-1:0]      data_n;
    logic signed [XW-1:0]   exp_adj;

    assign s2_load  = ~out_valid_q | bus.out_ready;
    assign in_ready = ~s1_valid_q | s2_load;

    // Index of the highest set bit of the incoming magnitude (0 when zero).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        lead_p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (bus.in_mag[i]) lead_p = PW'(i);
        end
    end

    // S1: capture the beat and its leading-one position.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_rmode_q <= '0;
            s1_exp_q   <= '0;
            s1_mag_q   <= '0;
            s1_p_q     <= '0;
            s1_zero_q  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q  <= bus.in_sign;
                s1_rmode_q <= bus.in_rmode;
                s1_exp_q   <= bus.in_exp;
                s1_mag_q   <= bus.in_mag;
                s1_p_q     <= lead_p;
                s1_zero_q  <= (bus.in_mag == '0);
            end
        end
    end

    // S2 datapath: normalize, sticky-collapse, rebias and pick the flag outcome.
    always_comb begin
        shamt    = PW'(FW) - s1_p_q;
        shifted  = s1_mag_q << shamt;                       // leading one lands on bit IN_W-1
        frac_pad = PADW'(shifted[IN_W-2:0]) << (PADW - FW); // hidden bit dropped, MSB-aligned
        tail     = frac_pad << DATA_W;                      // only the bits below the kept field
        data_n   = frac_pad[PADW-1 -: DATA_W];
        data_n[0] = data_n[0] | (|tail);

        exp_adj = {s1_exp_q[EXP_W+1], s1_exp_q} + XW'(s1_p_q) - XW'(IN_W - 2);

        out_zero_d = 1'b0;
        out_unf_d  = 1'b0;
        out_ovf_d  = 1'b0;
        out_exp_d  = '0;
        out_data_d = '0;
        if (s1_zero_q) begin
            out_zero_d = 1'b1;
        end else if (exp_adj[XW-1] || exp_adj == '0) begin
            out_unf_d = 1'b1;
        end else if (exp_adj >= EXP_INF) begin
            out_ovf_d = 1'b1;
            out_exp_d = '1;
        end else begin
            out_exp_d  = exp_adj[EXP_W-1:0];
            out_data_d = data_n;
        end
    end

    // S2: output register, advances whenever the downstream slot is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_rmode_q <= '0;
            out_exp_q   <= '0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign_q  <= s1_sign_q;
                out_rmode_q <= s1_rmode_q;
                out_exp_q   <= out_exp_d;
                out_data_q  <= out_data_d;
                out_zero_q  <= out_zero_d;
                out_ovf_q   <= out_ovf_d;
                out_unf_q   <= out_unf_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_rmode = out_rmode_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;
endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Self-checking bench for fp_mant_normalizer: arithmetic reference model with
// a scoreboard queue, directed corner vectors, backpressure, full-rate stream,
// randomized traffic with random stalls, and reset while beats are in flight.
module tb_fp_mant_normalizer;
    localparam int IN_W   = 48;
    localparam int DATA_W = 32;
    localparam int EXP_W  = 8;
    localparam int BUDGET = 50;

    typedef struct packed {
        logic        sign;
        logic [1:0]  rmode;
        logic [9:0]  exp;
        logic [47:0] mag;
    } beat_t;

    typedef struct packed {
        logic        sign;
        logic [1:0]  rmode;
        logic [7:0]  exp;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        unf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    res_t sb[$];
    int   push_cnt, pop_cnt;
    int   first_push_cyc, first_pop_cyc, last_pop_cyc;
    bit   rand_done;

    fp_mant_normalizer_if #(.IN_W(IN_W), .DATA_W(DATA_W), .EXP_W(EXP_W)) bus ();

    fp_mant_normalizer #(.IN_W(IN_W), .DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: value = mag * 2^(exp - bias - 46); renormalize so the leading
    // one is the hidden bit, keep 32 fraction bits, OR the rest into bit 0.
    function automatic res_t model(input beat_t b);
        res_t        r;
        int          p;
        int          adj;
        logic [95:0] w;
        r       = '0;
        r.sign  = b.sign;
        r.rmode = b.rmode;
        if (b.mag == 48'h0) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 48; i++) if (b.mag[i]) p = i;
        adj = int'($signed(b.exp)) + p - 46;
        if (adj <= 0) begin
            r.unf = 1'b1;
        end else if (adj >= 255) begin
            r.ovf = 1'b1;
            r.exp = 8'hFF;
        end else begin
            r.exp  = 8'(adj);
            w      = 96'(b.mag) << (47 - p);
            w[47]  = 1'b0;
            r.data = w[46:15];
            if (w[14:0] != 15'h0) r.data[0] = 1'b1;
        end
        return r;
    endfunction

    function automatic res_t dut_out();
        res_t r;
        r.sign  = bus.out_sign;
        r.rmode = bus.out_rmode;
        r.exp   = bus.out_exp;
        r.data  = bus.out_data;
        r.zero  = bus.out_zero;
        r.ovf   = bus.out_ovf;
        r.unf   = bus.out_unf;
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    kind;
        b.sign  = 1'($urandom);
        b.rmode = 2'($urandom);
        kind    = $urandom_range(0, 9);
        if (kind == 0)      b.mag = 48'h0;
        else if (kind < 3)  b.mag = 48'({$urandom, $urandom});
        else                b.mag = (48'h8000_0000_0000 | 48'({$urandom, $urandom})) >> $urandom_range(0, 47);
        if ($urandom_range(0, 3) == 0) b.exp = 10'($urandom);
        else                           b.exp = 10'($urandom_range(20, 230));
        return b;
    endfunction

    // Compare process: scoreboard on handshakes plus hold-stability under stall.
    initial begin
        res_t cur, exp_r, hold_snap;
        bit   hold_v = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 0;
            end else begin
                cur = dut_out();
                if (hold_v && bus.out_valid) check("hold_stable", 64'(cur), 64'(hold_snap));
                hold_v    = bus.out_valid && !bus.out_ready;
                hold_snap = cur;
                if (bus.in_valid && bus.in_ready) begin
                    sb.push_back(model(beat_t'{bus.in_sign, bus.in_rmode, bus.in_exp, bus.in_mag}));
                    if (push_cnt == 0) first_push_cyc = cyc;
                    push_cnt++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 64'(cur), 64'h0);
                    end else begin
                        exp_r = sb.pop_front();
                        check($sformatf("beat%0d", pop_cnt), 64'(cur), 64'(exp_r));
                    end
                    if (pop_cnt == 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    pop_cnt++;
                end
            end
        end
    end

    // Offer one beat (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic send(input beat_t b, output int waits);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_sign  = b.sign;
        bus.in_rmode = b.rmode;
        bus.in_exp   = b.exp;
        bus.in_mag   = b.mag;
        waits = 0;
        while (1) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits >= BUDGET) begin
                check("send_timeout", 64'(waits), 64'h0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        beat_t vec[6];
        res_t  pin[6];
        int    w;
        int    pops_before;

        vec[0] = beat_t'{1'b1, 2'd0, 10'd127, 48'h8000_0000_0000};
        vec[1] = beat_t'{1'b0, 2'd1, 10'd127, 48'h4000_0000_0001};
        vec[2] = beat_t'{1'b0, 2'd0, 10'd127, 48'h5000_0000_0000};
        vec[3] = beat_t'{1'b1, 2'd3, 10'd127, 48'h0};
        vec[4] = beat_t'{1'b0, 2'd0, 10'd10,  48'h1};
        vec[5] = beat_t'{1'b0, 2'd2, 10'd254, 48'h8000_0000_0000};
        // Hand-derived. 0x5000.. has ones at bits 46 and 44: bit 46 becomes the
        // hidden one, so the first fraction bit is 0 and the second is 1.
        pin[0] = res_t'{1'b1, 2'd0, 8'd128, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        pin[1] = res_t'{1'b0, 2'd1, 8'd127, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        pin[2] = res_t'{1'b0, 2'd0, 8'd127, 32'h4000_0000, 1'b0, 1'b0, 1'b0};
        pin[3] = res_t'{1'b1, 2'd3, 8'd0,   32'h0000_0000, 1'b1, 1'b0, 1'b0};
        pin[4] = res_t'{1'b0, 2'd0, 8'd0,   32'h0000_0000, 1'b0, 1'b0, 1'b1};
        pin[5] = res_t'{1'b0, 2'd2, 8'hFF,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) check($sformatf("model_pin%0d", i), 64'(model(vec[i])), 64'(pin[i]));

        // Reset state
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_rmode = '0;
        bus.in_exp = '0; bus.in_mag = '0; bus.out_ready = 1'b0;
        push_cnt = 0; pop_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_outputs", 64'(dut_out()), 64'h0);
        rst_n = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);

        // Directed vectors with a latency probe on the first
        bus.out_ready = 1'b1;
        send(vec[0], w);
        check("latency_c1", 64'(bus.out_valid), 64'h0);
        @(posedge clk);
        #1;
        check("latency_c2", 64'(bus.out_valid), 64'h1);
        for (int i = 1; i < 6; i++) send(vec[i], w);
        drain();

        // Backpressure: two beats held, third refused
        bus.out_ready = 1'b0;
        pops_before = pop_cnt;
        send(vec[1], w); check("bp_accept1", 64'(w), 64'h0);
        send(vec[2], w); check("bp_accept2", 64'(w), 64'h0);
        bus.in_valid = 1'b1;
        bus.in_sign = vec[5].sign; bus.in_rmode = vec[5].rmode;
        bus.in_exp = vec[5].exp; bus.in_mag = vec[5].mag;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_refuse", 64'(bus.in_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(vec[5], w);
        send(vec[0], w);
        drain();
        check("bp_count", 64'(pop_cnt - pops_before), 64'd4);

        // Full-rate stream
        push_cnt = 0; pop_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            send(rand_beat(), w);
            check("stream_ready", 64'(w), 64'h0);
        end
        drain();
        check("stream_count", 64'(pop_cnt), 64'd16);
        check("stream_latency", 64'(first_pop_cyc - first_push_cyc), 64'd2);
        check("stream_span", 64'(last_pop_cyc - first_pop_cyc), 64'd15);

        // Random traffic with random stalls and gaps
        push_cnt = 0; pop_cnt = 0;
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(rand_beat(), w);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", 64'(pop_cnt), 64'd60);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        send(vec[0], w);
        send(vec[1], w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("midrst_out_valid", 64'(bus.out_valid), 64'h0);
        check("midrst_outputs", 64'(dut_out()), 64'h0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'h1);
        rst_n = 1'b1;
        pop_cnt = 0;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("midrst_stale", 64'(pop_cnt), 64'h0);

        // Recovery after reset
        for (int i = 0; i < 6; i++) send(vec[i], w);
        drain();
        check("recover_count", 64'(pop_cnt), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
